// File: rtl/responder_pkg.sv
// responder_pkg: shared constants for the quiz-responder slice.
// State codes, BCD digit width, the "no player" code and a BCD countdown helper.
package responder_pkg;

  localparam int BCD_W = 4;

  localparam logic [3:0] PLAYER_NONE = 4'd0;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_ARMED  = 3'd1;
  localparam state_t ST_LOCKED = 3'd2;
  localparam state_t ST_DONE   = 3'd3;
  localparam state_t ST_FOUL   = 3'd4;

  // Two-digit BCD decrement that saturates at 00.
  function automatic logic [2*BCD_W-1:0] bcd_dec(input logic [2*BCD_W-1:0] v);
    logic [2*BCD_W-1:0] r;
    if (v == 8'h00) begin
      r = 8'h00;
    end else if (v[BCD_W-1:0] == 4'd0) begin
      r = {v[2*BCD_W-1:BCD_W] - 4'd1, 4'd9};
    end else begin
      r = {v[2*BCD_W-1:BCD_W], v[BCD_W-1:0] - 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/responder_if.sv
// responder_if: host/key inputs and display/beeper outputs of responder_ctrl.
// master = host side (drives Start/Clear/keys), slave = responder_ctrl.
interface responder_if
  import responder_pkg::*;
#(
  parameter int N_PLAYERS = 4
);

  logic                 Start;
  logic                 Clear;
  logic [N_PLAYERS-1:0] Player_Key;
  logic [3:0]           Player_Number;
  logic [BCD_W-1:0]     TimerH;
  logic [BCD_W-1:0]     TimerL;
  logic                 Buzzer;
  logic                 Foul;

  modport master (
    output Start, Clear, Player_Key,
    input  Player_Number, TimerH, TimerL, Buzzer, Foul
  );

  modport slave (
    input  Start, Clear, Player_Key,
    output Player_Number, TimerH, TimerL, Buzzer, Foul
  );

endinterface

// File: rtl/responder_tick.sv
// responder_tick: TICK_DIV prescaler. restart forces the count to 0 so the
// next full period begins on the following cycle; tick is a registered
// single-cycle pulse in the last cycle of each period.
module responder_tick #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic             tick_r;

  // Next count: restart or wrap to zero, otherwise advance.
  always_comb begin
    cnt_next_s = cnt_r;
    if (restart) begin
      cnt_next_s = '0;
    end else if (cnt_r == LAST) begin
      cnt_next_s = '0;
    end else begin
      cnt_next_s = cnt_r + CNT_W'(1);
    end
  end

  // Counter and registered tick, high while the count sits at LAST.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_r  <= '0;
      tick_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_next_s;
      tick_r <= (cnt_next_s == LAST);
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/responder_ctrl.sv
// responder_ctrl: quiz-responder round sequencer.
// Arms a buzz-in window, locks the first (lowest-index) pressing player,
// runs a BCD seconds countdown and drives the beeper.
// Optional early-press detection is compiled in with RESPONDER_FOUL_EN.
module responder_ctrl
  import responder_pkg::*;
#(
  parameter int N_PLAYERS  = 4,
  parameter int TICK_DIV   = 50_000_000,
  parameter int ARM_SEC    = 20,
  parameter int ANSWER_SEC = 30
) (
  input  logic        CLK,
  input  logic        RST_N,
  responder_if.slave  bus
);

  localparam logic [2*BCD_W-1:0] ARM_BCD = {4'(ARM_SEC / 10), 4'(ARM_SEC % 10)};
  localparam logic [2*BCD_W-1:0] ANS_BCD = {4'(ANSWER_SEC / 10), 4'(ANSWER_SEC % 10)};

  state_t             state_r, state_next_s;
  logic [3:0]         player_r, player_next_s;
  logic [2*BCD_W-1:0] timer_r, timer_next_s;
  logic               buzz_r, buzz_next_s;
  logic               foul_r, foul_next_s;
  logic               beep_s;
  logic               key_any_s;
  logic [3:0]         win_s;
  logic               sec_tick_s, sec_restart_s;
  logic               buzz_done_s, buzz_restart_s;
  logic               counting_s;

  assign key_any_s = |bus.Player_Key;

  // Priority encoder: lowest pressed index wins, reported 1-based.
  always_comb begin
    win_s = PLAYER_NONE;
    for (int i = N_PLAYERS - 1; i >= 0; i--) begin
      if (bus.Player_Key[i]) begin
        win_s = 4'(i + 1);
      end else begin
        win_s = win_s;
      end
    end
  end

  // Round sequencing; Clear acts as the synchronous soft reset and wins over all else.
  always_comb begin
    state_next_s  = state_r;
    player_next_s = player_r;
    timer_next_s  = timer_r;
    foul_next_s   = foul_r;
    beep_s        = 1'b0;
    if (bus.Clear) begin
      state_next_s  = ST_IDLE;
      player_next_s = PLAYER_NONE;
      timer_next_s  = 8'h00;
      foul_next_s   = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.Start) begin
            state_next_s = ST_ARMED;
            timer_next_s = ARM_BCD;
          end
`ifdef RESPONDER_FOUL_EN
          else if (key_any_s) begin
            state_next_s  = ST_FOUL;
            player_next_s = win_s;
            foul_next_s   = 1'b1;
            beep_s        = 1'b1;
          end
`endif
          else begin
            state_next_s = ST_IDLE;
          end
        end
        ST_ARMED: begin
          if (key_any_s) begin
            state_next_s  = ST_LOCKED;
            player_next_s = win_s;
            timer_next_s  = ANS_BCD;
            beep_s        = 1'b1;
          end else if (sec_tick_s) begin
            if (timer_r == 8'h00) begin
              state_next_s = ST_DONE;
              beep_s       = 1'b1;
            end else begin
              timer_next_s = bcd_dec(timer_r);
            end
          end else begin
            state_next_s = ST_ARMED;
          end
        end
        ST_LOCKED: begin
          if (sec_tick_s) begin
            if (timer_r == 8'h00) begin
              state_next_s = ST_DONE;
              beep_s       = 1'b1;
            end else begin
              timer_next_s = bcd_dec(timer_r);
            end
          end else begin
            state_next_s = ST_LOCKED;
          end
        end
        ST_DONE: begin
          state_next_s = ST_DONE;
        end
        ST_FOUL: begin
`ifdef RESPONDER_FOUL_EN
          state_next_s = ST_FOUL;
`else
          state_next_s  = ST_IDLE;
          player_next_s = PLAYER_NONE;
          timer_next_s  = 8'h00;
          foul_next_s   = 1'b0;
`endif
        end
        default: begin
          state_next_s  = ST_IDLE;
          player_next_s = PLAYER_NONE;
          timer_next_s  = 8'h00;
          foul_next_s   = 1'b0;
        end
      endcase
    end
  end

  // Beeper: set on entry events (retrigger restarts), cleared after one tick period.
  always_comb begin
    buzz_next_s = buzz_r;
    if (bus.Clear) begin
      buzz_next_s = 1'b0;
    end else if (beep_s) begin
      buzz_next_s = 1'b1;
    end else if (buzz_done_s) begin
      buzz_next_s = 1'b0;
    end else begin
      buzz_next_s = buzz_r;
    end
  end

  // Seconds prescaler only runs while counting, and restarts on every state entry.
  assign counting_s    = (state_r == ST_ARMED) || (state_r == ST_LOCKED);
  assign sec_restart_s = bus.Clear || (state_next_s != state_r) || !counting_s;
  assign buzz_restart_s = bus.Clear || beep_s || !buzz_r;

  responder_tick #(.TICK_DIV(TICK_DIV)) u_sec_tick (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .restart (sec_restart_s),
    .tick    (sec_tick_s)
  );

  responder_tick #(.TICK_DIV(TICK_DIV)) u_buzz_tick (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .restart (buzz_restart_s),
    .tick    (buzz_done_s)
  );

  // State and registered display/beeper outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r  <= ST_IDLE;
      player_r <= PLAYER_NONE;
      timer_r  <= 8'h00;
      buzz_r   <= 1'b0;
      foul_r   <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      player_r <= player_next_s;
      timer_r  <= timer_next_s;
      buzz_r   <= buzz_next_s;
      foul_r   <= foul_next_s;
    end
  end

  assign bus.Player_Number = player_r;
  assign bus.TimerH        = timer_r[2*BCD_W-1:BCD_W];
  assign bus.TimerL        = timer_r[BCD_W-1:0];
  assign bus.Buzzer        = buzz_r;
  assign bus.Foul          = foul_r;

endmodule

// File: tb/tb_responder_ctrl.sv
// tb_responder_ctrl: directed bench for responder_ctrl with TICK_DIV=4, ARM_SEC=3.
// Two instances: ANSWER_SEC=5 for the main flows, ANSWER_SEC=12 for BCD borrow.
// Observed outputs are packed as {Player_Number, TimerH, TimerL, Buzzer, Foul}.
module tb_responder_ctrl;

  logic CLK = 1'b0;
  logic RST_N;

  always #5 CLK = ~CLK;

  responder_if #(.N_PLAYERS(4)) bus5 ();
  responder_if #(.N_PLAYERS(4)) bus12 ();

  responder_ctrl #(.N_PLAYERS(4), .TICK_DIV(4), .ARM_SEC(3), .ANSWER_SEC(5)) u_dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus5)
  );

  responder_ctrl #(.N_PLAYERS(4), .TICK_DIV(4), .ARM_SEC(3), .ANSWER_SEC(12)) u_dut12 (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus12)
  );

  logic [13:0] obs5_s, obs12_s;
  assign obs5_s  = {bus5.Player_Number, bus5.TimerH, bus5.TimerL, bus5.Buzzer, bus5.Foul};
  assign obs12_s = {bus12.Player_Number, bus12.TimerH, bus12.TimerL, bus12.Buzzer, bus12.Foul};

  int checks_cnt = 0;
  int errors_cnt = 0;

  function automatic logic [13:0] exp_out(input logic [3:0] p, input logic [3:0] th,
                                          input logic [3:0] tl, input logic b, input logic f);
    return {p, th, tl, b, f};
  endfunction

  task automatic check_eq(input string tag, input logic [13:0] got, input logic [13:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=%h exp=%h (P/TH/TL/B/F packed)", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic start5();
    bus5.Start = 1'b1;
    step(1);
    bus5.Start = 1'b0;
  endtask

  task automatic clear5();
    bus5.Clear = 1'b1;
    step(1);
    bus5.Clear = 1'b0;
  endtask

  initial begin
    RST_N = 1'b0;
    bus5.Start = 1'b0;  bus5.Clear = 1'b0;  bus5.Player_Key = 4'b0000;
    bus12.Start = 1'b0; bus12.Clear = 1'b0; bus12.Player_Key = 4'b0000;
    step(2);
    check_eq("rst_outs", obs5_s, 14'h0);
    check_eq("rst_outs12", obs12_s, 14'h0);
    @(negedge CLK);
    RST_N = 1'b1;
    step(20);
    check_eq("idle_hold", obs5_s, 14'h0);

    // Start, lock player 3 two ticks later, buzzer length, lock held.
    start5();
    check_eq("arm_load", obs5_s, exp_out(4'd0, 4'd0, 4'd3, 1'b0, 1'b0));
    step(3);
    check_eq("first_sec_full", obs5_s, exp_out(4'd0, 4'd0, 4'd3, 1'b0, 1'b0));
    step(1);
    check_eq("arm_tick1", obs5_s, exp_out(4'd0, 4'd0, 4'd2, 1'b0, 1'b0));
    step(4);
    check_eq("arm_tick2", obs5_s, exp_out(4'd0, 4'd0, 4'd1, 1'b0, 1'b0));
    bus5.Player_Key = 4'b0100;
    step(1);
    bus5.Player_Key = 4'b0000;
    check_eq("lock_p3", obs5_s, exp_out(4'd3, 4'd0, 4'd5, 1'b1, 1'b0));
    step(3);
    check_eq("buzz_last", obs5_s, exp_out(4'd3, 4'd0, 4'd5, 1'b1, 1'b0));
    step(1);
    check_eq("buzz_off_tick", obs5_s, exp_out(4'd3, 4'd0, 4'd4, 1'b0, 1'b0));
    bus5.Player_Key = 4'b0001;
    step(2);
    bus5.Player_Key = 4'b0000;
    check_eq("lock_held", obs5_s, exp_out(4'd3, 4'd0, 4'd4, 1'b0, 1'b0));
    clear5();
    check_eq("clear_locked", obs5_s, 14'h0);

    // Simultaneous presses: lowest index wins.
    start5();
    bus5.Player_Key = 4'b1010;
    step(1);
    bus5.Player_Key = 4'b0000;
    check_eq("simul_p2", obs5_s, exp_out(4'd2, 4'd0, 4'd5, 1'b1, 1'b0));
    clear5();
    check_eq("clear_simul", obs5_s, 14'h0);

    // No press: 03,02,01,00 then DONE one tick later.
    start5();
    check_eq("to_03", obs5_s, exp_out(4'd0, 4'd0, 4'd3, 1'b0, 1'b0));
    step(4);
    check_eq("to_02", obs5_s, exp_out(4'd0, 4'd0, 4'd2, 1'b0, 1'b0));
    step(4);
    check_eq("to_01", obs5_s, exp_out(4'd0, 4'd0, 4'd1, 1'b0, 1'b0));
    step(4);
    check_eq("to_00", obs5_s, exp_out(4'd0, 4'd0, 4'd0, 1'b0, 1'b0));
    step(3);
    check_eq("to_00_held", obs5_s, exp_out(4'd0, 4'd0, 4'd0, 1'b0, 1'b0));
    step(1);
    check_eq("to_done_buzz", obs5_s, exp_out(4'd0, 4'd0, 4'd0, 1'b1, 1'b0));
    bus5.Player_Key = 4'b0001;
    step(3);
    check_eq("done_key_ignored", obs5_s, exp_out(4'd0, 4'd0, 4'd0, 1'b1, 1'b0));
    step(1);
    bus5.Player_Key = 4'b0000;
    check_eq("done_buzz_off", obs5_s, 14'h0);
    start5();
    step(4);
    check_eq("start_in_done", obs5_s, 14'h0);
    clear5();

    // BCD borrow on the ANSWER_SEC=12 instance, then LOCKED -> DONE keeps player.
    bus12.Start = 1'b1;
    step(1);
    bus12.Start = 1'b0;
    check_eq("b_arm", obs12_s, exp_out(4'd0, 4'd0, 4'd3, 1'b0, 1'b0));
    bus12.Player_Key = 4'b0001;
    step(1);
    bus12.Player_Key = 4'b0000;
    check_eq("b_12", obs12_s, exp_out(4'd1, 4'd1, 4'd2, 1'b1, 1'b0));
    step(4);
    check_eq("b_11", obs12_s, exp_out(4'd1, 4'd1, 4'd1, 1'b0, 1'b0));
    step(4);
    check_eq("b_10", obs12_s, exp_out(4'd1, 4'd1, 4'd0, 1'b0, 1'b0));
    step(4);
    check_eq("b_09", obs12_s, exp_out(4'd1, 4'd0, 4'd9, 1'b0, 1'b0));
    step(36);
    check_eq("b_00", obs12_s, exp_out(4'd1, 4'd0, 4'd0, 1'b0, 1'b0));
    step(3);
    check_eq("b_00_held", obs12_s, exp_out(4'd1, 4'd0, 4'd0, 1'b0, 1'b0));
    step(1);
    check_eq("b_done", obs12_s, exp_out(4'd1, 4'd0, 4'd0, 1'b1, 1'b0));
    bus12.Clear = 1'b1;
    step(1);
    bus12.Clear = 1'b0;
    check_eq("b_clear", obs12_s, 14'h0);

    // Same-cycle Clear and Start, in IDLE and in ARMED.
    bus5.Clear = 1'b1;
    bus5.Start = 1'b1;
    step(1);
    bus5.Clear = 1'b0;
    bus5.Start = 1'b0;
    check_eq("clr_start_idle", obs5_s, 14'h0);
    step(8);
    check_eq("clr_start_idle_hold", obs5_s, 14'h0);
    start5();
    step(2);
    bus5.Clear = 1'b1;
    bus5.Start = 1'b1;
    step(1);
    bus5.Clear = 1'b0;
    bus5.Start = 1'b0;
    check_eq("clr_start_armed", obs5_s, 14'h0);
    step(4);
    check_eq("clr_start_armed_hold", obs5_s, 14'h0);

    // Key press in IDLE.
    bus5.Player_Key = 4'b0010;
    step(1);
    bus5.Player_Key = 4'b0000;
`ifdef RESPONDER_FOUL_EN
    check_eq("foul_p2", obs5_s, exp_out(4'd2, 4'd0, 4'd0, 1'b1, 1'b1));
    start5();
    check_eq("foul_start_ignored", obs5_s, exp_out(4'd2, 4'd0, 4'd0, 1'b1, 1'b1));
    step(6);
    check_eq("foul_hold", obs5_s, exp_out(4'd2, 4'd0, 4'd0, 1'b0, 1'b1));
    clear5();
    check_eq("foul_clear", obs5_s, 14'h0);
`else
    check_eq("idle_key_ignored", obs5_s, 14'h0);
    start5();
    check_eq("arm_after_idle_key", obs5_s, exp_out(4'd0, 4'd0, 4'd3, 1'b0, 1'b0));
    clear5();
    check_eq("clear_after_idle_key", obs5_s, 14'h0);
`endif

    // Asynchronous reset mid-round aborts immediately, no resume.
    start5();
    step(2);
    #2;
    RST_N = 1'b0;
    #1;
    check_eq("async_rst", obs5_s, 14'h0);
    @(negedge CLK);
    RST_N = 1'b1;
    step(6);
    check_eq("async_rst_no_resume", obs5_s, 14'h0);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
